// File: rtl/dlx_mc_sequencer.sv
// Multi-cycle DLX control sequencer: walks one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB and drives the memory, IR, PC and register-file strobes.
module dlx_mc_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        memAck,
   input  logic        branchTaken,
   output logic        memReq,
   output logic        memWe,
   output logic        memAddrSel,
   output logic        irWr,
   output logic        pcWr,
   output logic [1:0]  pcSrc,
   output logic        regWr,
   output logic [2:0]  state,
   output logic        halted,
   output logic        busErr,
   output logic [31:0] instrCount
);

   // Counter only needs to hold 0..MEM_TIMEOUT-1; the terminal value triggers ERR.
   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_REG = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_ALU,
      C_LOAD,
      C_STORE,
      C_BRANCH,
      C_J,
      C_JR,
      C_JAL,
      C_JALR,
      C_TRAP
   } iclass_t;

   function automatic iclass_t classify(input logic [5:0] op);
      iclass_t c;
      case (op)
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: c = C_LOAD;
         6'h28, 6'h29, 6'h2b:               c = C_STORE;
         6'h04, 6'h05:                      c = C_BRANCH;
         6'h02:                             c = C_J;
         6'h12:                             c = C_JR;
         6'h03:                             c = C_JAL;
         6'h13:                             c = C_JALR;
         6'h11:                             c = C_TRAP;
         default:                           c = C_ALU;
      endcase
      return c;
   endfunction

   state_t        state_q, state_d;
   iclass_t       cls_q, cls_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [31:0]   cnt_q, cnt_d;

   logic       req, we, asel, ir_wr, pc_wr, reg_wr;
   logic [1:0] pc_src;

   // Only the opcode field matters to sequencing; operand fields go to the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[25:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cls_q   <= C_ALU;
         tmo_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      tmo_d   = '0;
      req     = 1'b0;
      we      = 1'b0;
      asel    = 1'b0;
      ir_wr   = 1'b0;
      pc_wr   = 1'b0;
      reg_wr  = 1'b0;
      pc_src  = PC_SEQ;

      case (state_q)
         S_FETCH: begin
            req = 1'b1;
            if (memAck) begin
               ir_wr   = 1'b1;
               state_d = S_DECODE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_DECODE: begin
            cls_d   = classify(instr[31:26]);
            state_d = S_EXEC;
         end

         S_EXEC: begin
            case (cls_q)
               C_LOAD, C_STORE: state_d = S_MEM;
               C_BRANCH: begin
                  pc_wr   = 1'b1;
                  pc_src  = branchTaken ? PC_BR : PC_SEQ;
                  state_d = S_FETCH;
               end
               C_J: begin
                  pc_wr   = 1'b1;
                  pc_src  = PC_JMP;
                  state_d = S_FETCH;
               end
               C_JR: begin
                  pc_wr   = 1'b1;
                  pc_src  = PC_REG;
                  state_d = S_FETCH;
               end
               C_TRAP:  state_d = S_HALT;
               default: state_d = S_WB;
            endcase
         end

         S_MEM: begin
            req  = 1'b1;
            asel = 1'b1;
            we   = (cls_q == C_STORE);
            // Ack in the terminal cycle still completes the access.
            if (memAck) begin
               if (cls_q == C_STORE) begin
                  pc_wr   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         S_WB: begin
            reg_wr = 1'b1;
            pc_wr  = 1'b1;
            if (cls_q == C_JAL) begin
               pc_src = PC_JMP;
            end else if (cls_q == C_JALR) begin
               pc_src = PC_REG;
            end
            state_d = S_FETCH;
         end

         S_HALT: state_d = S_HALT;
         S_ERR:  state_d = S_ERR;
         default: state_d = S_FETCH;
      endcase

      cnt_d = pc_wr ? (cnt_q + 32'd1) : cnt_q;
   end

   // Strobes are forced low while reset is held so an abort never leaks a partial access.
   assign memReq     = req & rst_n;
   assign memWe      = we & rst_n;
   assign memAddrSel = asel & rst_n;
   assign irWr       = ir_wr & rst_n;
   assign pcWr       = pc_wr & rst_n;
   assign regWr      = reg_wr & rst_n;
   assign pcSrc      = pc_src;
   assign state      = state_q;
   assign halted     = (state_q == S_HALT);
   assign busErr     = (state_q == S_ERR);
   assign instrCount = cnt_q;

endmodule

// File: tb/tb_dlx_mc_sequencer.sv
// Scoreboard bench for dlx_mc_sequencer: a program-level model predicts every strobe
// event (cycle and values); a memory responder plays back the per-access ack delays.
module tb_dlx_mc_sequencer;

   localparam int TMO = 15;

   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_J = 4,
                  K_JR = 5, K_JAL = 6, K_JALR = 7, K_TRAP = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        memAck = 1'b0;
   logic        branchTaken = 1'b0;
   logic        memReq, memWe, memAddrSel, irWr, pcWr, regWr, halted, busErr;
   logic [1:0]  pcSrc;
   logic [2:0]  state;
   logic [31:0] instrCount;

   dlx_mc_sequencer #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .memAck(memAck),
      .branchTaken(branchTaken), .memReq(memReq), .memWe(memWe),
      .memAddrSel(memAddrSel), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc),
      .regWr(regWr), .state(state), .halted(halted), .busErr(busErr),
      .instrCount(instrCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      bit          bt;
      int          df;
      int          dm;
   } item_t;

   typedef struct {
      int          cyc;
      logic [2:0]  st;
      logic        ir, pw, rw, we, asel;
      logic [1:0]  src;
      logic [31:0] cnt;
   } ev_t;

   item_t prog[$];
   ev_t   sb[$];
   ev_t   me;
   int    n_cmp = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    ip = 0, cur = 0, wt = 0;
   bit    active = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int mclass(input logic [5:0] op);
      if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_LOAD;
      if (op inside {6'h28, 6'h29, 6'h2b}) return K_STORE;
      if (op inside {6'h04, 6'h05}) return K_BR;
      if (op == 6'h02) return K_J;
      if (op == 6'h12) return K_JR;
      if (op == 6'h03) return K_JAL;
      if (op == 6'h13) return K_JALR;
      if (op == 6'h11) return K_TRAP;
      return K_ALU;
   endfunction

   function automatic logic [31:0] gen_instr(input int k);
      logic [5:0] op;
      case (k)
         K_LOAD:  case ($urandom_range(0, 4))
                     0: op = 6'h20; 1: op = 6'h21; 2: op = 6'h23; 3: op = 6'h24;
                     default: op = 6'h25;
                  endcase
         K_STORE: case ($urandom_range(0, 2))
                     0: op = 6'h28; 1: op = 6'h29;
                     default: op = 6'h2b;
                  endcase
         K_BR:    op = ($urandom_range(0, 1) == 1) ? 6'h04 : 6'h05;
         K_J:     op = 6'h02;
         K_JR:    op = 6'h12;
         K_JAL:   op = 6'h03;
         K_JALR:  op = 6'h13;
         K_TRAP:  op = 6'h11;
         default: begin
            op = 6'($urandom_range(0, 63));
            while (mclass(op) != K_ALU) op = 6'($urandom_range(0, 63));
         end
      endcase
      return {op, 26'($urandom())};
   endfunction

   function automatic int gen_delay();
      int r = $urandom_range(0, 7);
      if (r == 7) return TMO - 1;
      return r % 3;
   endfunction

   function automatic void add(input logic [31:0] ins, input bit bt, input int df, input int dm);
      item_t it;
      it.ins = ins; it.bt = bt; it.df = df; it.dm = dm;
      prog.push_back(it);
   endfunction

   function automatic void pushev(input int c, input logic [2:0] st, input logic ir, input logic pw,
                                  input logic rw, input logic we, input logic asel,
                                  input logic [1:0] src, input logic [31:0] cnt);
      ev_t e;
      e.cyc = c; e.st = st; e.ir = ir; e.pw = pw; e.rw = rw; e.we = we; e.asel = asel;
      e.src = pw ? src : 2'b00; e.cnt = cnt;
      sb.push_back(e);
   endfunction

   // Program-level timing model: cycle 0 is the first FETCH after reset release.
   task automatic model_and_push(output int endcyc, output logic [2:0] endst, output logic [31:0] endcnt);
      int t = 0;
      int x;
      logic [31:0] c = 32'd0;
      endcyc = -1; endst = 3'd0; endcnt = 32'd0;
      foreach (prog[i]) begin
         if (prog[i].df >= TMO) begin
            endcyc = t + TMO; endst = 3'd7; endcnt = c;
            return;
         end
         pushev(t + prog[i].df, 3'd0, 1, 0, 0, 0, 0, 2'b00, c);
         x = t + prog[i].df + 3;   // first cycle after EXEC
         case (mclass(prog[i].ins[31:26]))
            K_LOAD, K_STORE: begin
               if (prog[i].dm >= TMO) begin
                  endcyc = x + TMO; endst = 3'd7; endcnt = c;
                  return;
               end
               if (mclass(prog[i].ins[31:26]) == K_STORE) begin
                  pushev(x + prog[i].dm, 3'd3, 0, 1, 0, 1, 1, 2'b00, c);
                  c++;
                  t = x + prog[i].dm + 1;
               end else begin
                  pushev(x + prog[i].dm, 3'd3, 0, 0, 0, 0, 1, 2'b00, c);
                  pushev(x + prog[i].dm + 1, 3'd4, 0, 1, 1, 0, 0, 2'b00, c);
                  c++;
                  t = x + prog[i].dm + 2;
               end
            end
            K_BR: begin
               pushev(x - 1, 3'd2, 0, 1, 0, 0, 0, prog[i].bt ? 2'b01 : 2'b00, c);
               c++; t = x;
            end
            K_J:  begin pushev(x - 1, 3'd2, 0, 1, 0, 0, 0, 2'b10, c); c++; t = x; end
            K_JR: begin pushev(x - 1, 3'd2, 0, 1, 0, 0, 0, 2'b11, c); c++; t = x; end
            K_JAL:  begin pushev(x, 3'd4, 0, 1, 1, 0, 0, 2'b10, c); c++; t = x + 1; end
            K_JALR: begin pushev(x, 3'd4, 0, 1, 1, 0, 0, 2'b11, c); c++; t = x + 1; end
            K_TRAP: begin
               endcyc = x; endst = 3'd6; endcnt = c;
               return;
            end
            default: begin pushev(x, 3'd4, 0, 1, 1, 0, 0, 2'b00, c); c++; t = x + 1; end
         endcase
      end
      endcnt = c;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Memory responder: each access acks after the programmed number of wait cycles;
   // while no request is pending memAck is randomised to show it is ignored.
   always @(negedge clk) begin
      if (!rst_n) begin
         active = 0;
         memAck = 1'b0;
      end else if (memReq) begin
         if (!active) begin
            active = 1;
            if (memAddrSel) wt = (cur < prog.size()) ? prog[cur].dm : 0;
            else            wt = (ip < prog.size()) ? prog[ip].df : 0;
         end
         if (wt == 0) begin
            memAck = 1'b1;
            active = 0;
            if (!memAddrSel) begin
               instr       = (ip < prog.size()) ? prog[ip].ins : 32'h44000000;
               branchTaken = (ip < prog.size()) ? prog[ip].bt : 1'b0;
               cur = ip;
               ip++;
            end
         end else begin
            memAck = 1'b0;
            wt--;
         end
      end else begin
         active = 0;
         memAck = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: every strobe or completed access is popped from the scoreboard and compared.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && (irWr || pcWr || regWr || (memReq && memAck))) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: state %0d irWr %0b pcWr %0b regWr %0b, expected no event (cycle %0d)",
                     state, irWr, pcWr, regWr, cyc);
         end else begin
            me = sb.pop_front();
            chk("event_cycle", 64'(cyc), 64'(me.cyc));
            chk("event_fields",
                {state, irWr, pcWr, regWr, memWe, memAddrSel, (pcWr ? pcSrc : 2'b00), instrCount},
                {me.st, me.ir, me.pw, me.rw, me.we, me.asel, me.src, me.cnt});
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      sb.delete();
      ip = 0;
      cur = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_values",
          {state, instrCount, halted, busErr, memReq, memWe, irWr, pcWr, regWr},
          64'd0);
   endtask

   task automatic release_dut();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("fetch_after_release", {memReq, memAddrSel, memWe, irWr, state}, {4'b1000, 3'd0});
   endtask

   task automatic run_prog(input string tag);
      int ec;
      logic [2:0] es;
      logic [31:0] ecnt;
      bit done;
      do_reset();
      model_and_push(ec, es, ecnt);
      release_dut();
      done = 0;
      for (int i = 0; i < ec + 40 && !done; i++) begin
         @(negedge clk);
         #2;
         if (halted || busErr) done = 1;
      end
      chk({tag, "_end_reached"}, done, 1);
      if (done) begin
         chk({tag, "_end_cycle"}, 64'(cyc), 64'(ec));
         chk({tag, "_end_state"}, state, es);
         chk({tag, "_end_count"}, instrCount, ecnt);
         chk({tag, "_end_flags"}, {halted, busErr}, (es == 3'd6) ? 2'b10 : 2'b01);
         repeat (3) begin
            @(negedge clk);
            #2;
            chk({tag, "_idle_strobes"}, {memReq, memWe, irWr, pcWr, regWr, state}, {5'b0, es});
         end
      end
      chk({tag, "_scoreboard_drained"}, sb.size(), 0);
   endtask

   task automatic abort_test();
      int ec;
      logic [2:0] es;
      logic [31:0] ecnt;
      bit seen;
      prog.delete();
      add(32'h00000020, 0, 0, 0);
      add(32'h8C000000, 0, 0, 12);
      add(32'h44000000, 0, 0, 0);
      do_reset();
      model_and_push(ec, es, ecnt);
      release_dut();
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         #2;
         if (state == 3'd3) seen = 1;
      end
      chk("abort_reached_mem", seen, 1);
      repeat (2) @(negedge clk);
      chk("abort_count_before", instrCount, 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_outputs",
          {memReq, memAddrSel, memWe, irWr, pcWr, regWr, state, instrCount}, 64'd0);
      sb.delete();
   endtask

   task automatic build_random();
      int n = $urandom_range(3, 10);
      prog.delete();
      for (int i = 0; i < n; i++)
         add(gen_instr($urandom_range(0, 7)), 1'($urandom_range(0, 1)), gen_delay(), gen_delay());
      case ($urandom_range(0, 5))
         0: add(gen_instr(K_ALU), 0, TMO + $urandom_range(0, 2), 0);
         1: add(gen_instr($urandom_range(K_LOAD, K_STORE)), 0, gen_delay(), TMO + $urandom_range(0, 2));
         default: add(gen_instr(K_TRAP), 0, gen_delay(), 0);
      endcase
   endtask

   initial begin
      prog.delete();
      add(32'h00000020, 0, 0, 0);
      add(32'h8C000000, 0, 0, 3);
      add(32'h10000000, 1, 0, 0);
      add(32'h10000000, 0, 0, 0);
      add(32'h4C000000, 0, 0, 0);
      add(32'hAC000000, 0, 0, 0);
      add(32'h44000000, 0, 0, 0);
      run_prog("directed");

      prog.delete();
      add(32'h00000020, 0, TMO, 0);
      run_prog("fetch_timeout");

      prog.delete();
      add(32'h00000020, 0, TMO - 1, 0);
      add(32'h44000000, 0, 0, 0);
      run_prog("fetch_ack_at_limit");

      prog.delete();
      add(32'h8C000000, 0, 1, TMO - 1);
      add(32'hAC000000, 0, 0, TMO);
      run_prog("mem_limit_then_timeout");

      abort_test();

      for (int r = 0; r < 25; r++) begin
         build_random();
         run_prog("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dlx_mc_sequencer.md
# dlx_mc_sequencer

Multi-cycle sequencer for the DLX datapath. It drives the shared fetch/data memory port, the instruction register, PC update and register-file write strobes, one instruction at a time. It classifies each instruction from its opcode and walks it through FETCH, DECODE, EXEC, MEM and WB. Per-signal ALU and operand decode stays in the existing combinational `control` unit, which this block sequences. Memory latency is variable and handled by a req/ack handshake with a timeout.

## Interface
- `MEM_TIMEOUT`, default 15: number of cycles `memReq` may stay high without `memAck` before the bus-error state is entered.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `instr`  in  32: IR contents; valid from DECODE onward; opcode = `instr[31:26]`.
- `memAck`  in  1: memory completion; sampled only while `memReq`=1.
- `branchTaken`  in  1: datapath zero-test result for BEQZ/BNEZ; valid in EXEC.
- `memReq`  out  1: memory access request, held until ack.
- `memWe`  out  1: store access, qualified by `memReq`.
- `memAddrSel`  out  1: 0 = PC (fetch), 1 = ALU result (data).
- `irWr`  out  1: load IR from memory read data.
- `pcWr`  out  1: update PC.
- `pcSrc`  out  2: selects the next PC value:
  - 00 = PC+4
  - 01 = branch target
  - 10 = J/JAL target
  - 11 = register (JR/JALR)
- `regWr`  out  1: register-file write.
- `state`  out  3: current state, for debug.
- `halted`  out  1: TRAP executed.
- `busErr`  out  1: memory timeout occurred.
- `instrCount`  out  32: retired-instruction count.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=6, ERR=7.
- Opcode classes:
  - LOAD: 0x20, 0x21, 0x23, 0x24, 0x25.
  - STORE: 0x28, 0x29, 0x2b.
  - BRANCH: 0x04 (BEQZ), 0x05 (BNEZ).
  - JUMP: 0x02 (J), 0x03 (JAL), 0x12 (JR), 0x13 (JALR). 0x03 and 0x13 are link instructions.
  - TRAP: 0x11.
  - ALU: everything else, including R-type 0x00.
- FETCH: `memReq`=1, `memAddrSel`=0, `memWe`=0. On ack: `irWr`=1 for that cycle, next state DECODE.
- DECODE: one cycle, no strobes. Next state EXEC.
- EXEC transitions by class:
  - ALU: go to WB.
  - LOAD/STORE: go to MEM.
  - BRANCH: `pcWr`=1, `pcSrc`=01 if `branchTaken` else 00; go to FETCH.
  - JUMP, non-link: `pcWr`=1, `pcSrc`=10 (0x02) or 11 (0x12); go to FETCH.
  - JUMP, link: go to WB.
  - TRAP: go to HALT.
- MEM: `memReq`=1, `memAddrSel`=1, `memWe`=1 for STORE. On ack:
  - LOAD: go to WB.
  - STORE: `pcWr`=1, `pcSrc`=00; go to FETCH.
- WB: `regWr`=1 and `pcWr`=1 in the same cycle.
  - `pcSrc` = 00 for ALU/LOAD, 10 for JAL, 11 for JALR.
  - Next state FETCH.
- `instrCount` increments by 1 on every cycle with `pcWr`=1. It wraps from 0xFFFFFFFF to 0.
- TRAP does not increment `instrCount`.
- HALT: `halted`=1; all strobes 0; stays in HALT until reset.
- ERR: `busErr`=1; all strobes 0; stays in ERR until reset.
- Timeout counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle that `memReq`=1 and `memAck`=0.
  - When it reaches `MEM_TIMEOUT` with ack still low, next state is ERR.
  - Ack arriving in that same cycle wins: the access completes normally.
- `memAck` while `memReq`=0 is ignored.

## Timing
- Reset values: state FETCH; `instrCount` 0; `halted` 0; `busErr` 0; timeout counter 0.
- `memReq`=1 immediately out of reset, since the state is FETCH. All other strobes are 0 during reset.
- All outputs are Moore decodes of registered state, except:
  - `irWr` and the MEM-exit `pcWr`, which are gated by `memAck`.
  - EXEC `pcSrc` for branches, which depends on `branchTaken`.
- Minimum cycles per instruction, with ack on the first request cycle:
  - ALU 4
  - LOAD 5
  - STORE 4
  - BRANCH 3
  - J/JR 3
  - JAL/JALR 4
- Each extra wait cycle adds 1 to these figures.
- Reset asserted mid-instruction aborts immediately:
  - `memReq` drops asynchronously.
  - No partial `regWr`/`pcWr` occurs.
  - The first cycle after reset release is FETCH.

## Test plan
- Reset, then ALU instr 0x00000020 with ack on the first cycle -> states 0,1,2,4. `irWr` pulses in cycle 1; `regWr`=`pcWr`=1 in cycle 4 with `pcSrc`=00; `instrCount`=1.
- LW (0x8C000000) with data ack delayed 3 cycles -> `memReq`/`memAddrSel`=1 held 4 cycles in MEM, then WB with `regWr`=1; 8 cycles total.
- BEQZ (0x10000000) with `branchTaken`=1, then again with `branchTaken`=0 -> `pcWr` in EXEC with `pcSrc`=01, then with `pcSrc`=00; `regWr` never asserted.
- JALR (0x4C000000) -> WB asserts `regWr`=1, `pcWr`=1, `pcSrc`=11. SW (0xAC000000) -> `memWe`=1 in MEM and no WB state.
- `memAck` held low for 15 cycles in FETCH (`MEM_TIMEOUT`=15) -> `busErr`=1, state 7, all strobes 0. A second run with ack on the 15th cycle -> completes normally with no error.
- TRAP (0x44000000) -> `halted`=1, state 6, `instrCount` unchanged. Asserting `rst_n`=0 mid-MEM -> `memReq` drops within the same cycle, counters return to 0.
